// File: rtl/aes_pkg.sv
// Shared AES constants: word/state widths, scheduler FSM encoding and the
// forward S-box table with its byte lookup.
package aes_pkg;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_SUB  = 2'd2
    } state_t;

    typedef enum logic {
        GR_KX = 1'b0,
        GR_SB = 1'b1
    } grant_t;

    // Entry 0x00 sits in the top byte, so index n lives at bits [(255-n)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_TABLE[{8'hff - b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sbox_word.sv
// Four parallel forward S-box lookups on a 32-bit word; purely combinational.
module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_word[8*g +: 8] = sbox_byte(i_word[8*g +: 8]);
    end

endmodule

// File: rtl/sbox_scheduler.sv
// Round-robin arbiter sharing one 32-bit S-box unit between key-expansion
// SubWord requests and 128-bit SubBytes jobs (run as four column passes).
module sbox_scheduler
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                kx_req_valid,
    input  logic [WORD_W-1:0]   kx_req_word,
    output logic                kx_req_ready,
    output logic                kx_rsp_valid,
    output logic [WORD_W-1:0]   kx_rsp_word,
    input  logic                sb_req_valid,
    input  logic [STATE_W-1:0]  sb_req_state,
    output logic                sb_req_ready,
    output logic                sb_rsp_valid,
    output logic [STATE_W-1:0]  sb_rsp_state,
    output logic                busy
);

    state_t               r_state;
    logic [1:0]           r_col;
    grant_t               r_last_grant;
    logic [WORD_W-1:0]    r_kx_word;
    logic [STATE_W-1:0]   r_sb_state;
    logic                 r_kx_rsp_valid;
    logic [WORD_W-1:0]    r_kx_rsp_word;
    logic                 r_sb_rsp_valid;
    logic [STATE_W-1:0]   r_sb_rsp_state;

    logic                 w_kx_grant;
    logic                 w_sb_grant;
    logic [WORD_W-1:0]    w_col_word;
    logic [WORD_W-1:0]    w_lut_in;
    logic [WORD_W-1:0]    w_lut_out;

    // On a tie the requester that did not win last time is granted.
    assign w_kx_grant = kx_req_valid & (~sb_req_valid | (r_last_grant == GR_SB));
    assign w_sb_grant = sb_req_valid & (~kx_req_valid | (r_last_grant == GR_KX));

    assign kx_req_ready = ~rst & (r_state == ST_IDLE) & w_kx_grant;
    assign sb_req_ready = ~rst & (r_state == ST_IDLE) & w_sb_grant;
    assign busy         = (r_state != ST_IDLE);

    always_comb begin
        w_col_word = r_sb_state[127:96];
        case (r_col)
            2'd0:    w_col_word = r_sb_state[127:96];
            2'd1:    w_col_word = r_sb_state[95:64];
            2'd2:    w_col_word = r_sb_state[63:32];
            default: w_col_word = r_sb_state[31:0];
        endcase
    end

    assign w_lut_in = (r_state == ST_KEY) ? r_kx_word : w_col_word;

    sbox_word u_sbox_word (
        .i_word (w_lut_in),
        .o_word (w_lut_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_col          <= 2'd0;
            r_last_grant   <= GR_SB;
            r_kx_word      <= '0;
            r_sb_state     <= '0;
            r_kx_rsp_valid <= 1'b0;
            r_kx_rsp_word  <= '0;
            r_sb_rsp_valid <= 1'b0;
            r_sb_rsp_state <= '0;
        end else begin
            r_kx_rsp_valid <= 1'b0;
            r_sb_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_kx_grant) begin
                        r_kx_word    <= kx_req_word;
                        r_last_grant <= GR_KX;
                        r_state      <= ST_KEY;
                    end else if (w_sb_grant) begin
                        r_sb_state   <= sb_req_state;
                        r_last_grant <= GR_SB;
                        r_col        <= 2'd0;
                        r_state      <= ST_SUB;
                    end
                end
                ST_KEY: begin
                    r_kx_rsp_word  <= w_lut_out;
                    r_kx_rsp_valid <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                ST_SUB: begin
                    case (r_col)
                        2'd0:    r_sb_rsp_state[127:96] <= w_lut_out;
                        2'd1:    r_sb_rsp_state[95:64]  <= w_lut_out;
                        2'd2:    r_sb_rsp_state[63:32]  <= w_lut_out;
                        default: r_sb_rsp_state[31:0]   <= w_lut_out;
                    endcase
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_sb_rsp_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign kx_rsp_valid = r_kx_rsp_valid;
    assign kx_rsp_word  = r_kx_rsp_word;
    assign sb_rsp_valid = r_sb_rsp_valid;
    assign sb_rsp_state = r_sb_rsp_state;

endmodule
